// File: rtl/midi_pkg.sv
// Shared constants and FSM encoding for the polyphonic MIDI voice allocator.
package midi_pkg;

   localparam logic [3:0] MSG_NOTE_OFF = 4'h8;
   localparam logic [3:0] MSG_NOTE_ON  = 4'h9;
   localparam logic [3:0] MSG_CC       = 4'hB;
   localparam logic [3:0] MSG_PBEND    = 4'hE;

   localparam logic [6:0] CC_MOD  = 7'd1;
   localparam logic [6:0] CC_SUST = 7'd64;
   localparam logic [6:0] CC_ANO  = 7'd123;

   localparam logic [13:0] PBEND_CENTER = 14'h2000;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t SCAN   = 2'd1;
   localparam state_t COMMIT = 2'd2;

endpackage

// File: rtl/midi_voice_slot.sv
// One tone-generator voice: note/velocity, gate, sustain-held flag and a saturating age.
module midi_voice_slot #(
   parameter int unsigned AGE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             do_assign,
   input  logic             do_release,
   input  logic             sustain_release,
   input  logic             all_off,
   input  logic             age_inc,
   input  logic             sustain,
   input  logic [6:0]       note_in,
   input  logic [6:0]       vel_in,
   input  logic [6:0]       match_note,
   output logic             gate,
   output logic [6:0]       note,
   output logic [6:0]       vel,
   output logic [AGE_W-1:0] age,
   output logic             match
);

   logic             gate_q, held_q;
   logic [6:0]       note_q, vel_q;
   logic [AGE_W-1:0] age_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gate_q <= 1'b0;
         held_q <= 1'b0;
         note_q <= '0;
         vel_q  <= '0;
         age_q  <= '0;
      end else if (do_assign) begin
         note_q <= note_in;
         vel_q  <= vel_in;
         gate_q <= 1'b1;
         held_q <= 1'b0;
         age_q  <= '0;
      end else begin
         if (age_inc && (age_q != '1)) age_q <= age_q + 1'b1;
         if (all_off) begin
            gate_q <= 1'b0;
            held_q <= 1'b0;
         end else if (do_release) begin
            // With the pedal down the voice keeps sounding until the pedal lifts.
            if (sustain) held_q <= 1'b1;
            else         gate_q <= 1'b0;
         end else if (sustain_release && held_q) begin
            gate_q <= 1'b0;
            held_q <= 1'b0;
         end
      end
   end

   assign gate  = gate_q;
   assign note  = note_q;
   assign vel   = vel_q;
   assign age   = age_q;
   assign match = gate_q && (note_q == match_note);

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: sequential voice scan, then a single commit cycle.
module midi_voice_alloc
   import midi_pkg::*;
#(
   parameter int unsigned NUM_VOICES = 8,
   parameter int unsigned VIDX_W     = 3,
   parameter int unsigned AGE_W      = 8,
   parameter bit          OMNI       = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    midi_command_ready,
   input  logic [3:0]              chan,
   input  logic [3:0]              chan_sel,
   input  logic [3:0]              ch_message,
   input  logic [6:0]              note_in,
   input  logic [6:0]              velocity_in,
   input  logic [6:0]              lsb_in,
   input  logic [6:0]              msb_in,
   output logic                    busy,
   output logic                    cmd_drop,
   output logic [NUM_VOICES-1:0]   gate,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_vel,
   output logic [NUM_VOICES-1:0]   trig,
   output logic [13:0]             pitch_bend,
   output logic [6:0]              mod_wheel,
   output logic                    sustain
);

   localparam logic [VIDX_W-1:0] LastIdx = VIDX_W'(NUM_VOICES - 1);

   state_t                  state_q;
   logic [VIDX_W-1:0]       idx_q, hit_idx_q, free_idx_q, old_idx_q, target;
   logic                    hit_q, free_q, note_on_q;
   logic [AGE_W-1:0]        old_age_q;
   logic [NUM_VOICES-1:0]   rel_mask_q;
   logic [6:0]              note_q, vel_q, mod_q;
   logic [13:0]             pitch_bend_q;
   logic                    sustain_q, cmd_drop_q;
   logic [NUM_VOICES-1:0]   trig_q;

   logic [NUM_VOICES-1:0]   s_match, assign_vec, release_vec, age_inc_vec;
   logic [AGE_W-1:0]        s_age [NUM_VOICES];
   logic                    take, accept, is_note, is_cc, commit, sust_rel, all_off;

   assign take    = midi_command_ready && en && (OMNI || (chan == chan_sel));
   assign accept  = take && (state_q == IDLE);
   assign is_note = (ch_message == MSG_NOTE_ON) || (ch_message == MSG_NOTE_OFF);
   assign is_cc   = (ch_message == MSG_CC);
   assign commit  = (state_q == COMMIT);

   // Pedal-up and All Notes Off act in the acceptance cycle, not via the scan.
   assign sust_rel = accept && is_cc && (note_in == CC_SUST) && sustain_q && !velocity_in[6];
   assign all_off  = accept && is_cc && (note_in == CC_ANO) && !sustain_q;

   // Priority: retrigger a sounding copy, else first free voice, else steal the oldest.
   assign target = hit_q ? hit_idx_q : (free_q ? free_idx_q : old_idx_q);

   always_comb begin
      assign_vec  = '0;
      release_vec = '0;
      age_inc_vec = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         assign_vec[i]  = commit && note_on_q && (target == VIDX_W'(i));
         age_inc_vec[i] = commit && note_on_q && (target != VIDX_W'(i));
         release_vec[i] = commit && !note_on_q && rel_mask_q[i];
      end
   end

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      midi_voice_slot #(
         .AGE_W(AGE_W)
      ) u_slot (
         .clk            (clk),
         .rst            (rst),
         .do_assign      (assign_vec[i]),
         .do_release     (release_vec[i]),
         .sustain_release(sust_rel),
         .all_off        (all_off),
         .age_inc        (age_inc_vec[i]),
         .sustain        (sustain_q),
         .note_in        (note_q),
         .vel_in         (vel_q),
         .match_note     (note_q),
         .gate           (gate[i]),
         .note           (voice_note[7*i +: 7]),
         .vel            (voice_vel[7*i +: 7]),
         .age            (s_age[i]),
         .match          (s_match[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         hit_q        <= 1'b0;
         hit_idx_q    <= '0;
         free_q       <= 1'b0;
         free_idx_q   <= '0;
         old_idx_q    <= '0;
         old_age_q    <= '0;
         rel_mask_q   <= '0;
         note_on_q    <= 1'b0;
         note_q       <= '0;
         vel_q        <= '0;
         mod_q        <= '0;
         pitch_bend_q <= PBEND_CENTER;
         sustain_q    <= 1'b0;
         cmd_drop_q   <= 1'b0;
         trig_q       <= '0;
      end else begin
         cmd_drop_q <= take && (state_q != IDLE);
         trig_q     <= assign_vec;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_note) begin
                     state_q    <= SCAN;
                     idx_q      <= '0;
                     note_on_q  <= (ch_message == MSG_NOTE_ON) && (velocity_in != 7'd0);
                     note_q     <= note_in;
                     vel_q      <= velocity_in;
                     hit_q      <= 1'b0;
                     free_q     <= 1'b0;
                     old_idx_q  <= '0;
                     old_age_q  <= '0;
                     rel_mask_q <= '0;
                  end else if (ch_message == MSG_PBEND) begin
                     pitch_bend_q <= {msb_in, lsb_in};
                  end else if (is_cc) begin
                     if (note_in == CC_MOD)  mod_q     <= velocity_in;
                     if (note_in == CC_SUST) sustain_q <= velocity_in[6];
                  end
               end
            end
            SCAN: begin
               if (s_match[idx_q] && !hit_q) begin
                  hit_q     <= 1'b1;
                  hit_idx_q <= idx_q;
               end
               if (!gate[idx_q] && !free_q) begin
                  free_q     <= 1'b1;
                  free_idx_q <= idx_q;
               end
               // Strict compare keeps the lowest index on equal ages.
               if ((idx_q == '0) || (s_age[idx_q] > old_age_q)) begin
                  old_idx_q <= idx_q;
                  old_age_q <= s_age[idx_q];
               end
               rel_mask_q[idx_q] <= s_match[idx_q];
               if (idx_q == LastIdx) state_q <= COMMIT;
               else                  idx_q   <= idx_q + 1'b1;
            end
            COMMIT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = (state_q != IDLE);
   assign cmd_drop   = cmd_drop_q;
   assign trig       = trig_q;
   assign pitch_bend = pitch_bend_q;
   assign mod_wheel  = mod_q;
   assign sustain    = sustain_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed plus randomized bench for midi_voice_alloc against a behavioural voice model.
module tb_midi_voice_alloc;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst, en, rdy;
   logic [3:0]     chan, chan_sel, ch_message;
   logic [6:0]     note_in, velocity_in, lsb_in, msb_in;
   logic           busy, cmd_drop, sustain;
   logic [N-1:0]   gate, trig;
   logic [7*N-1:0] voice_note, voice_vel;
   logic [13:0]    pitch_bend;
   logic [6:0]     mod_wheel;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic         m_gate [N];
   logic         m_held [N];
   logic [6:0]   m_note [N];
   logic [6:0]   m_vel  [N];
   int           m_age  [N];
   logic [13:0]  m_pb;
   logic [6:0]   m_mod;
   logic         m_sus;
   logic [N-1:0] m_trig;

   midi_voice_alloc u_dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .midi_command_ready(rdy),
      .chan              (chan),
      .chan_sel          (chan_sel),
      .ch_message        (ch_message),
      .note_in           (note_in),
      .velocity_in       (velocity_in),
      .lsb_in            (lsb_in),
      .msb_in            (msb_in),
      .busy              (busy),
      .cmd_drop          (cmd_drop),
      .gate              (gate),
      .voice_note        (voice_note),
      .voice_vel         (voice_vel),
      .trig              (trig),
      .pitch_bend        (pitch_bend),
      .mod_wheel         (mod_wheel),
      .sustain           (sustain)
   );

   always #10 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_gate[i] = 0; m_held[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
      m_pb = 14'h2000; m_mod = 0; m_sus = 0; m_trig = 0;
   endtask

   task automatic model_apply(input logic [3:0] st, input logic [6:0] n, v, l, m);
      int tgt;
      m_trig = 0;
      if (st == 4'h9 && v != 0) begin
         tgt = -1;
         for (int i = 0; i < N; i++) if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
         for (int i = 0; i < N; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
         if (tgt < 0) begin
            tgt = 0;
            for (int i = 1; i < N; i++) if (m_age[i] > m_age[tgt]) tgt = i;
         end
         for (int i = 0; i < N; i++) begin
            if (i == tgt) begin
               m_note[i] = n; m_vel[i] = v; m_gate[i] = 1; m_held[i] = 0; m_age[i] = 0;
            end else if (m_age[i] < 255) begin
               m_age[i]++;
            end
         end
         m_trig[tgt] = 1'b1;
      end else if (st == 4'h8 || st == 4'h9) begin
         for (int i = 0; i < N; i++)
            if (m_gate[i] && m_note[i] == n) begin
               if (m_sus) m_held[i] = 1;
               else       m_gate[i] = 0;
            end
      end else if (st == 4'hB) begin
         if (n == 1) m_mod = v;
         if (n == 64) begin
            if (m_sus && !v[6])
               for (int i = 0; i < N; i++)
                  if (m_held[i]) begin m_gate[i] = 0; m_held[i] = 0; end
            m_sus = v[6];
         end
         if (n == 123 && !m_sus)
            for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_held[i] = 0; end
      end else if (st == 4'hE) begin
         m_pb = {m, l};
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0]   eg;
      logic [7*N-1:0] en_v, ev_v;
      for (int i = 0; i < N; i++) begin
         eg[i] = m_gate[i];
         en_v[7*i +: 7] = m_note[i];
         ev_v[7*i +: 7] = m_vel[i];
      end
      chk({tag, ".gate"}, gate, eg);
      chk({tag, ".note"}, voice_note, en_v);
      chk({tag, ".vel"}, voice_vel, ev_v);
      chk({tag, ".trig"}, trig, m_trig);
      chk({tag, ".pbend"}, pitch_bend, m_pb);
      chk({tag, ".mod"}, mod_wheel, m_mod);
      chk({tag, ".sus"}, sustain, m_sus);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".drop"}, cmd_drop, 0);
   endtask

   task automatic drive(input logic [3:0] st, c, input logic [6:0] n, v, l, m);
      @(negedge clk);
      ch_message = st; chan = c; note_in = n; velocity_in = v; lsb_in = l; msb_in = m;
      rdy = 1'b1;
   endtask

   task automatic issue(input string tag, input logic [3:0] st, c, input logic [6:0] n, v, l, m);
      bit acc, isnote;
      drive(st, c, n, v, l, m);
      acc    = en && (c == chan_sel);
      isnote = acc && (st == 4'h8 || st == 4'h9);
      @(posedge clk); #1;
      rdy = 1'b0;
      if (acc) model_apply(st, n, v, l, m);
      else     m_trig = 0;
      if (isnote) begin
         chk({tag, ".busy_scan"}, busy, 1);
         repeat (N + 1) @(posedge clk);
         #1;
      end
      check_all(tag);
   endtask

   initial begin
      logic [3:0] st, c;
      logic [6:0] n, v;
      int r;
      rst = 1'b0; en = 1'b1; rdy = 1'b0; chan = 0; chan_sel = 0; ch_message = 0;
      note_in = 0; velocity_in = 0; lsb_in = 0; msb_in = 0;
      model_reset();
      #25;
      check_all("reset");
      @(negedge clk); rst = 1'b1;

      issue("on60", 4'h9, 0, 60, 100, 0, 0);
      @(posedge clk); #1;
      chk("on60.trig_once", trig, 0);
      m_trig = 0;
      for (int k = 61; k <= 67; k++) issue("fill", 4'h9, 0, 7'(k), 7'(k + 10), 0, 0);
      issue("steal68", 4'h9, 0, 68, 33, 0, 0);
      chk("steal68.voice0", voice_note[6:0], 68);
      issue("retrig64", 4'h9, 0, 64, 77, 0, 0);
      chk("retrig64.trig4", trig, 8'h10);

      issue("sus_on", 4'hB, 0, 64, 127, 0, 0);
      issue("off61_held", 4'h8, 0, 61, 0, 0, 0);
      chk("off61_held.gate1", gate[1], 1);
      issue("ano_ignored", 4'hB, 0, 123, 0, 0, 0);
      issue("sus_off", 4'hB, 0, 64, 0, 0, 0);
      chk("sus_off.note_kept", voice_note[13:7], 61);

      issue("on72", 4'h9, 0, 72, 90, 0, 0);
      issue("on72_v0", 4'h9, 0, 72, 0, 0, 0);
      issue("mod", 4'hB, 0, 1, 42, 0, 0);
      issue("pbend", 4'hE, 0, 0, 0, 7'h7F, 7'h7F);
      chk("pbend.max", pitch_bend, 14'h3FFF);

      // Command arriving mid-scan is dropped and must leave state untouched
      drive(4'h9, 0, 50, 60, 0, 0);
      @(posedge clk); #1;
      rdy = 1'b0;
      model_apply(4'h9, 50, 60, 0, 0);
      drive(4'hE, 0, 0, 0, 7'h00, 7'h00);
      @(posedge clk); #1;
      rdy = 1'b0;
      chk("drop.pulse", cmd_drop, 1);
      @(posedge clk); #1;
      chk("drop.pulse_end", cmd_drop, 0);
      repeat (N - 1) @(posedge clk);
      #1;
      check_all("drop");

      issue("wrong_chan", 4'h9, 3, 20, 50, 0, 0);
      en = 1'b0;
      issue("en_low", 4'h9, 0, 21, 50, 0, 0);
      en = 1'b1;
      issue("ano", 4'hB, 0, 123, 0, 0, 0);

      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 9);
         n = 7'($urandom_range(60, 71));
         v = 7'($urandom_range(0, 127));
         c = ($urandom_range(0, 7) == 0) ? 4'd3 : chan_sel;
         en = ($urandom_range(0, 9) != 0);
         case (r)
            0, 1, 2: st = 4'h9;
            3, 4:    st = 4'h8;
            5: begin st = 4'hB; n = 64; end
            6: begin st = 4'hB; n = ($urandom_range(0, 3) == 0) ? 7'd123 : 7'd1; end
            7:       st = 4'hE;
            8:       st = 4'hB;
            default: st = 4'hA;
         endcase
         issue("rand", st, c, n, v, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
      end
      en = 1'b1;

      // Reset in the middle of a scan
      drive(4'h9, 0, 99, 99, 0, 0);
      @(posedge clk); #1;
      rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midscan.busy_before", busy, 1);
      rst = 1'b0;
      #1;
      model_reset();
      check_all("midscan_reset");
      @(negedge clk); rst = 1'b1;
      repeat (N + 2) @(posedge clk);
      #1;
      check_all("after_reset_idle");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
